// File: rtl/debounce_pkg.sv
// Shared constants, pulse FSM encoding and counter sizing
// for the debounce_array switch conditioner.
package debounce_pkg;

   localparam int DEF_STABLE_CYCLES = 16;
   localparam int DEF_PULSE_CYCLES  = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } pulse_st_t;

   // Never returns 0 so a count of 1 still gets a real register.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce_if.sv
// Raw-in / conditioned-out bundle for debounce_array.
// The slave side is the conditioner, the master side drives raw.
interface debounce_if #(
   parameter int CHANNELS = 4
) ();

   logic [CHANNELS-1:0] raw;
   logic [CHANNELS-1:0] clean;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] pulse;

   modport master (
      output raw,
      input  clean,
      input  rise,
      input  fall,
      input  pulse
   );

   modport slave (
      input  raw,
      output clean,
      output rise,
      output fall,
      output pulse
   );

endinterface

// File: rtl/debounce_channel.sv
// One conditioner bit: 2-FF sync, stability counter,
// registered edge strobes and a stretched pulse per rise.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
   parameter int RETRIGGER     = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall,
   output logic pulse
);

   localparam int CW = cnt_width(STABLE_CYCLES);
   localparam int PW = cnt_width(PULSE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [PW-1:0] PCNT_LOAD = PW'(PULSE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;
   logic          settle;
   logic          rise_d;
   logic          fall_d;
   pulse_st_t     st;
   pulse_st_t     st_n;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] pcnt_n;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Edge strobes are decided on the same edge that clean flips.
   assign settle = (s2 != clean) && (cnt == CNT_LAST);
   assign rise_d = settle & s2;
   assign fall_d = settle & ~s2;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= rise_d;
         fall <= fall_d;
         if (s2 == clean) begin
            cnt <= '0;
         end else if (settle) begin
            clean <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st    <= ST_IDLE;
         pcnt  <= '0;
         pulse <= 1'b0;
      end else begin
         st    <= st_n;
         pcnt  <= pcnt_n;
         pulse <= (st_n == ST_ACTIVE);
      end
   end

   always_comb begin
      st_n   = st;
      pcnt_n = pcnt;
      unique case (st)
         ST_IDLE: begin
            if (rise_d) begin
               st_n   = ST_ACTIVE;
               pcnt_n = PCNT_LOAD;
            end
         end
         ST_ACTIVE: begin
            if (rise_d && (RETRIGGER != 0)) begin
               pcnt_n = PCNT_LOAD;
            end else if (pcnt == '0) begin
               st_n = ST_IDLE;
            end else begin
               pcnt_n = pcnt - 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/debounce_array.sv
// N independent switch conditioners behind the board pins;
// wiring plus elaboration-time parameter range checks.
module debounce_array
   import debounce_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
   parameter int RETRIGGER     = 0
) (
   input logic       clock,
   input logic       reset,
   debounce_if.slave bus
);

   if (CHANNELS < 1) begin : g_bad_channels
      $error("debounce_array: CHANNELS must be >= 1");
   end
   if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("debounce_array: STABLE_CYCLES must be >= 2");
   end
   if (PULSE_CYCLES < 1) begin : g_bad_pulse
      $error("debounce_array: PULSE_CYCLES must be >= 1");
   end
   if ((RETRIGGER != 0) && (RETRIGGER != 1)) begin : g_bad_retrig
      $error("debounce_array: RETRIGGER must be 0 or 1");
   end

   logic [CHANNELS-1:0] clean_w;
   logic [CHANNELS-1:0] rise_w;
   logic [CHANNELS-1:0] fall_w;
   logic [CHANNELS-1:0] pulse_w;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .PULSE_CYCLES  (PULSE_CYCLES),
         .RETRIGGER     (RETRIGGER)
      ) u_ch (
         .clock (clock),
         .reset (reset),
         .raw   (bus.raw[i]),
         .clean (clean_w[i]),
         .rise  (rise_w[i]),
         .fall  (fall_w[i]),
         .pulse (pulse_w[i])
      );
   end

   assign bus.clean = clean_w;
   assign bus.rise  = rise_w;
   assign bus.fall  = fall_w;
   assign bus.pulse = pulse_w;

endmodule

// File: tb/tb_debounce_array.sv
// Directed scoreboard bench for debounce_array: reset, step,
// bounce, glitch, parallel channels and pulse retrigger.
module tb_debounce_array;

   typedef struct {
      string      tag;
      int         cyc;
      int         dut;
      int         sig;
      logic [1:0] exp;
   } item_t;

   localparam int M = 0;
   localparam int R = 1;
   localparam int N = 2;
   localparam int CLEAN = 0;
   localparam int RISE  = 1;
   localparam int FALL  = 2;
   localparam int PULSE = 3;

   item_t sb[$];
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] raw_m = 2'b00;
   logic       raw_r = 1'b0;

   debounce_if #(.CHANNELS(2)) ifm ();
   debounce_if #(.CHANNELS(1)) ifr ();
   debounce_if #(.CHANNELS(1)) ifn ();

   assign ifm.raw = raw_m;
   assign ifr.raw = raw_r;
   assign ifn.raw = raw_r;

   debounce_array #(
      .CHANNELS(2), .STABLE_CYCLES(4), .PULSE_CYCLES(3), .RETRIGGER(0)
   ) dut_m (.clock(clk), .reset(rst_n), .bus(ifm.slave));

   debounce_array #(
      .CHANNELS(1), .STABLE_CYCLES(4), .PULSE_CYCLES(20), .RETRIGGER(1)
   ) dut_r (.clock(clk), .reset(rst_n), .bus(ifr.slave));

   debounce_array #(
      .CHANNELS(1), .STABLE_CYCLES(4), .PULSE_CYCLES(20), .RETRIGGER(0)
   ) dut_n (.clock(clk), .reset(rst_n), .bus(ifn.slave));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1:0] obs(input int dut, input int sig);
      logic [1:0] v;
      v = 2'bxx;
      case (dut)
         M: case (sig)
               CLEAN: v = ifm.clean;
               RISE:  v = ifm.rise;
               FALL:  v = ifm.fall;
               default: v = ifm.pulse;
            endcase
         R: case (sig)
               CLEAN: v = {1'b0, ifr.clean};
               RISE:  v = {1'b0, ifr.rise};
               FALL:  v = {1'b0, ifr.fall};
               default: v = {1'b0, ifr.pulse};
            endcase
         default: case (sig)
               CLEAN: v = {1'b0, ifn.clean};
               RISE:  v = {1'b0, ifn.rise};
               FALL:  v = {1'b0, ifn.fall};
               default: v = {1'b0, ifn.pulse};
            endcase
      endcase
      return v;
   endfunction

   task automatic check(input string tag, input logic [1:0] o,
                        input logic [1:0] e);
      n_checks++;
      assert (o === e) else begin
         n_errors++;
         $error("FAIL %s @cyc %0d observed=%b expected=%b",
                tag, cyc, o, e);
      end
   endtask

   task automatic push(input string tag, input int d, input int dut,
                       input int sig, input logic [1:0] v);
      item_t it;
      it.tag = tag;
      it.cyc = cyc + d;
      it.dut = dut;
      it.sig = sig;
      it.exp = v;
      sb.push_back(it);
   endtask

   task automatic push_span(input string tag, input int d0, input int d1,
                            input int dut, input int sig,
                            input logic [1:0] v);
      for (int d = d0; d <= d1; d++) push(tag, d, dut, sig, v);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i].tag, obs(sb[i].dut, sb[i].sig), sb[i].exp);
            sb.delete(i);
         end
      end
   end

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_clean", ifm.clean, 2'b00);
      check("rst_rise",  ifm.rise,  2'b00);
      check("rst_fall",  ifm.fall,  2'b00);
      check("rst_pulse", ifm.pulse, 2'b00);
      tick(3);
      rst_n = 1'b1;
      tick(4);

      // step on ch0
      raw_m = 2'b01;
      push("step_clean_pre", 5, M, CLEAN, 2'b00);
      push("step_clean", 6, M, CLEAN, 2'b01);
      push("step_rise_pre", 5, M, RISE, 2'b00);
      push("step_rise", 6, M, RISE, 2'b01);
      push("step_rise_end", 7, M, RISE, 2'b00);
      push_span("step_pulse", 6, 8, M, PULSE, 2'b01);
      push("step_pulse_end", 9, M, PULSE, 2'b00);
      tick(12);

      raw_m = 2'b00;
      push("ch0_fall", 6, M, FALL, 2'b01);
      push("ch0_fall_end", 7, M, FALL, 2'b00);
      push("ch0_fall_clean", 6, M, CLEAN, 2'b00);
      tick(10);

      // bounce on ch0
      push_span("bnc_clean", 1, 32, M, CLEAN, 2'b00);
      push_span("bnc_rise", 1, 32, M, RISE, 2'b00);
      push_span("bnc_pulse", 1, 32, M, PULSE, 2'b00);
      for (int k = 0; k < 10; k++) begin
         raw_m[0] = ~raw_m[0];
         tick(2);
      end
      tick(12);

      // 3-cycle glitch on ch1
      raw_m[1] = 1'b1;
      push_span("glt_clean", 1, 14, M, CLEAN, 2'b00);
      push_span("glt_rise", 1, 14, M, RISE, 2'b00);
      tick(3);
      raw_m[1] = 1'b0;
      tick(11);

      raw_m[1] = 1'b1;
      push("ch1_clean_pre", 5, M, CLEAN, 2'b00);
      push("ch1_clean", 6, M, CLEAN, 2'b10);
      push("ch1_rise", 6, M, RISE, 2'b10);
      push("ch1_rise_end", 7, M, RISE, 2'b00);
      push_span("ch1_pulse", 6, 8, M, PULSE, 2'b10);
      push("ch1_pulse_end", 9, M, PULSE, 2'b00);
      tick(10);

      raw_m[1] = 1'b0;
      push("ch1_fall_pre", 5, M, FALL, 2'b00);
      push("ch1_fall", 6, M, FALL, 2'b10);
      push("ch1_fall_end", 7, M, FALL, 2'b00);
      push("ch1_fall_clean", 6, M, CLEAN, 2'b00);
      tick(10);

      // ch0 rises while ch1 falls on the same edge
      raw_m[1] = 1'b1;
      tick(10);
      raw_m = 2'b01;
      push("par_rise", 6, M, RISE, 2'b01);
      push("par_fall", 6, M, FALL, 2'b10);
      push("par_clean", 6, M, CLEAN, 2'b01);
      push("par_rise_end", 7, M, RISE, 2'b00);
      push("par_fall_end", 7, M, FALL, 2'b00);
      push("par_pulse", 6, M, PULSE, 2'b01);
      tick(10);

      // reset between edges mid-pulse
      raw_m = 2'b11;
      push("mid_clean", 6, M, CLEAN, 2'b11);
      push("mid_pulse", 7, M, PULSE, 2'b10);
      tick(7);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_clean", ifm.clean, 2'b00);
      check("mid_rst_rise",  ifm.rise,  2'b00);
      check("mid_rst_fall",  ifm.fall,  2'b00);
      check("mid_rst_pulse", ifm.pulse, 2'b00);
      tick(2);
      rst_n = 1'b1;
      push("rel_clean_pre", 5, M, CLEAN, 2'b00);
      push("rel_clean", 6, M, CLEAN, 2'b11);
      push("rel_rise", 6, M, RISE, 2'b11);
      push("rel_rise_end", 7, M, RISE, 2'b00);
      push_span("rel_pulse", 6, 8, M, PULSE, 2'b11);
      push("rel_pulse_end", 9, M, PULSE, 2'b00);
      tick(12);

      // second rise 15 cycles into a 20-cycle pulse
      raw_r = 1'b1;
      push("rt_pulse_pre", 5, R, PULSE, 2'b00);
      push_span("rt_pulse", 6, 40, R, PULSE, 2'b01);
      push("rt_pulse_end", 41, R, PULSE, 2'b00);
      push("rt_rise2", 21, R, RISE, 2'b01);
      push("rt_fall", 14, R, FALL, 2'b01);
      push_span("nr_pulse", 6, 25, N, PULSE, 2'b01);
      push_span("nr_pulse_end", 26, 45, N, PULSE, 2'b00);
      push("nr_rise2", 21, N, RISE, 2'b01);
      push("nr_fall", 14, N, FALL, 2'b01);
      tick(8);
      raw_r = 1'b0;
      tick(7);
      raw_r = 1'b1;
      tick(35);

      tick(3);
      check("sb_drained", {1'b0, sb.size() == 0}, 2'b01);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
